// File: rtl/pipeline_mem_pkg.sv
// Shared types and decoder control encodings for the data-memory arbiter.
// The memory model and the decoder use the same rd/wr control values.
package pipeline_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic {
        OWN_MEM = 1'b0,
        OWN_IF  = 1'b1
    } owner_t;

    localparam logic [2:0] RD_CTRL_NONE   = 3'd0;
    localparam logic [2:0] RD_CTRL_BYTE   = 3'd1;
    localparam logic [2:0] RD_CTRL_HALF   = 3'd2;
    localparam logic [2:0] RD_CTRL_WORD   = 3'd3;
    localparam logic [2:0] RD_CTRL_DWORD  = 3'd4;
    localparam logic [2:0] RD_CTRL_BYTE_U = 3'd5;
    localparam logic [2:0] RD_CTRL_HALF_U = 3'd6;
    localparam logic [2:0] RD_CTRL_WORD_U = 3'd7;

    localparam logic [1:0] WR_CTRL_NONE  = 2'd0;
    localparam logic [1:0] WR_CTRL_BYTE  = 2'd1;
    localparam logic [1:0] WR_CTRL_WORD  = 2'd2;
    localparam logic [1:0] WR_CTRL_DWORD = 2'd3;

    // A MEM-stage slot with neither a load nor a store needs no memory access.
    function automatic logic is_noop(input logic [2:0] rd_ctrl, input logic [1:0] wr_ctrl);
        return (rd_ctrl == RD_CTRL_NONE) && (wr_ctrl == WR_CTRL_NONE);
    endfunction

endpackage

// File: rtl/pipeline_mem_arb_pick.sv
// Grant selection: MEM wins ties unless its streak of consecutive wins over a
// waiting fetch has reached the limit, in which case fetch goes next.
module pipeline_mem_arb_pick #(
    parameter int MAX_MEM_STREAK = 4,
    parameter int STREAK_W       = 3
) (
    input  logic                i_mem_req,
    input  logic                i_if_req,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant_mem,
    output logic                o_grant_if
);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    logic w_streak_full;

    assign w_streak_full = (i_streak == STREAK_MAX);
    assign o_grant_if    = i_if_req & (~i_mem_req | w_streak_full);
    assign o_grant_mem   = i_mem_req & ~o_grant_if;

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Shares one data-memory port between the MEM stage and instruction fetch.
// Each access runs IDLE -> BUSY (req/ack) -> HOLD (done pulse) -> IDLE.
module pipeline_mem_arbiter
    import pipeline_mem_pkg::*;
#(
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_wdata,
    input  logic [2:0]  mem_rd_ctrl,
    input  logic [1:0]  mem_wr_ctrl,
    output logic        mem_done,
    output logic        mem_err,
    output logic [63:0] mem_rdata,
    output logic        mem_stall,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic        if_err,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    output logic        dm_req,
    output logic [63:0] dm_addr,
    output logic [63:0] dm_din,
    output logic [2:0]  dm_rd_ctrl,
    output logic [1:0]  dm_wr_ctrl,
    input  logic        dm_ack,
    input  logic [63:0] dm_dout,
    output logic [1:0]  dbg_state
);
    localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
    localparam int TO_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    logic [STREAK_W-1:0] r_streak;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_dm_req;
    logic [63:0]         r_dm_addr;
    logic [63:0]         r_dm_din;
    logic [2:0]          r_dm_rd_ctrl;
    logic [1:0]          r_dm_wr_ctrl;
    logic                r_mem_done;
    logic                r_mem_err;
    logic [63:0]         r_mem_rdata;
    logic                r_if_done;
    logic                r_if_err;
    logic [31:0]         r_if_rdata;

    logic w_pick_mem;
    logic w_pick_if;
    logic w_noop;
    logic w_start;
    logic w_finish;
    logic w_timeout;
    logic [63:0] w_rdata;

    pipeline_mem_arb_pick #(
        .MAX_MEM_STREAK (MAX_MEM_STREAK),
        .STREAK_W       (STREAK_W)
    ) u_pick (
        .i_mem_req   (mem_req),
        .i_if_req    (if_req),
        .i_streak    (r_streak),
        .o_grant_mem (w_pick_mem),
        .o_grant_if  (w_pick_if)
    );

    assign w_noop  = w_pick_mem & is_noop(mem_rd_ctrl, mem_wr_ctrl);
    // A timed-out access returns zero data rather than whatever is on the bus.
    assign w_rdata = w_timeout ? 64'd0 : dm_dout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_mem || w_pick_if) begin
                    w_start     = 1'b1;
                    w_state_nxt = w_noop ? HOLD : BUSY;
                end
            end
            BUSY: begin
                if (dm_ack) begin
                    w_finish    = 1'b1;
                    w_state_nxt = HOLD;
                end else if (r_to_cnt == TO_LAST) begin
                    w_finish    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_MEM;
            r_streak     <= '0;
            r_to_cnt     <= '0;
            r_dm_req     <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_din     <= '0;
            r_dm_rd_ctrl <= '0;
            r_dm_wr_ctrl <= '0;
            r_mem_done   <= 1'b0;
            r_mem_err    <= 1'b0;
            r_mem_rdata  <= '0;
            r_if_done    <= 1'b0;
            r_if_err     <= 1'b0;
            r_if_rdata   <= '0;
        end else begin
            if (w_start) begin
                r_to_cnt <= '0;
                if (w_pick_if) begin
                    r_owner      <= OWN_IF;
                    r_streak     <= '0;
                    r_dm_req     <= 1'b1;
                    r_dm_addr    <= if_addr;
                    r_dm_din     <= '0;
                    r_dm_rd_ctrl <= RD_CTRL_WORD_U;
                    r_dm_wr_ctrl <= WR_CTRL_NONE;
                end else begin
                    r_owner      <= OWN_MEM;
                    r_dm_addr    <= mem_addr;
                    r_dm_din     <= mem_wdata;
                    r_dm_rd_ctrl <= mem_rd_ctrl;
                    r_dm_wr_ctrl <= mem_wr_ctrl;
                    if (!if_req)                    r_streak <= '0;
                    else if (r_streak != STREAK_MAX) r_streak <= r_streak + STREAK_W'(1);
                    if (w_noop) begin
                        r_mem_done  <= 1'b1;
                        r_mem_err   <= 1'b0;
                        r_mem_rdata <= '0;
                    end else begin
                        r_dm_req <= 1'b1;
                    end
                end
            end else if (w_finish) begin
                r_dm_req <= 1'b0;
                r_to_cnt <= '0;
                if (r_owner == OWN_IF) begin
                    r_if_done  <= 1'b1;
                    r_if_err   <= w_timeout;
                    r_if_rdata <= w_rdata[31:0];
                end else begin
                    r_mem_done  <= 1'b1;
                    r_mem_err   <= w_timeout;
                    r_mem_rdata <= w_rdata;
                end
            end else if (r_state == BUSY) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else if (r_state == HOLD) begin
                r_mem_done <= 1'b0;
                r_mem_err  <= 1'b0;
                r_if_done  <= 1'b0;
                r_if_err   <= 1'b0;
            end
        end
    end

    assign mem_done   = r_mem_done;
    assign mem_err    = r_mem_err;
    assign mem_rdata  = r_mem_rdata;
    assign mem_stall  = mem_req & ~r_mem_done;
    assign if_done    = r_if_done;
    assign if_err     = r_if_err;
    assign if_rdata   = r_if_rdata;
    assign if_stall   = if_req & ~r_if_done;
    assign dm_req     = r_dm_req;
    assign dm_addr    = r_dm_addr;
    assign dm_din     = r_dm_din;
    assign dm_rd_ctrl = r_dm_rd_ctrl;
    assign dm_wr_ctrl = r_dm_wr_ctrl;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter: load, fetch, contention, no-op,
// timeout with stray ack, and reset in the middle of an access.
module tb_pipeline_mem_arbiter;
    import pipeline_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [2:0]  mem_rd_ctrl;
    logic [1:0]  mem_wr_ctrl;
    logic        mem_done;
    logic        mem_err;
    logic [63:0] mem_rdata;
    logic        mem_stall;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_done;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic [63:0] dm_addr;
    logic [63:0] dm_din;
    logic [2:0]  dm_rd_ctrl;
    logic [1:0]  dm_wr_ctrl;
    logic        dm_ack;
    logic [63:0] dm_dout;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_mem_arbiter #(.MAX_MEM_STREAK(4), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd_ctrl(mem_rd_ctrl), .mem_wr_ctrl(mem_wr_ctrl),
        .mem_done(mem_done), .mem_err(mem_err), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl),
        .dm_ack(dm_ack), .dm_dout(dm_dout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until dm_req rises, giving up after a few cycles.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dm_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit          ok;
        bit          exp_if;
        int          last_if;
        int          busy_cnt;
        logic [63:0] d;

        reset = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_rd_ctrl = '0; mem_wr_ctrl = '0; if_req = 1'b0; if_addr = '0;
        dm_ack = 1'b0; dm_dout = '0;
        step(); step();
        check("rst_dm_req", dm_req, 0);
        check("rst_dm_addr", dm_addr, 0);
        check("rst_done", {mem_done, mem_err, if_done, if_err}, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b0;

        // MEM load with zero-wait memory
        mem_req = 1'b1; mem_addr = 64'h100; mem_rd_ctrl = RD_CTRL_DWORD;
        step();
        check("ld_dm_req", dm_req, 1);
        check("ld_dm_addr", dm_addr, 64'h100);
        check("ld_dm_rd_ctrl", dm_rd_ctrl, RD_CTRL_DWORD);
        check("ld_stall_busy", mem_stall, 1);
        check("ld_done_early", mem_done, 0);
        dm_ack = 1'b1; dm_dout = 64'hDEAD_BEEF_0000_0001;
        step();
        dm_ack = 1'b0;
        check("ld_dm_req_drop", dm_req, 0);
        check("ld_done", mem_done, 1);
        check("ld_err", mem_err, 0);
        check("ld_rdata", mem_rdata, 64'hDEAD_BEEF_0000_0001);
        check("ld_stall_done", mem_stall, 0);
        check("ld_state_hold", dbg_state, HOLD);
        mem_req = 1'b0;
        step();
        check("ld_done_clear", mem_done, 0);
        check("ld_state_idle", dbg_state, IDLE);

        // IF fetch
        if_req = 1'b1; if_addr = 64'h80;
        step();
        check("if_dm_req", dm_req, 1);
        check("if_dm_addr", dm_addr, 64'h80);
        check("if_rd_ctrl", dm_rd_ctrl, RD_CTRL_WORD_U);
        check("if_wr_ctrl", dm_wr_ctrl, WR_CTRL_NONE);
        check("if_din", dm_din, 0);
        check("if_stall_busy", if_stall, 1);
        dm_ack = 1'b1; dm_dout = 64'h1234_5678_0013_0513;
        step();
        dm_ack = 1'b0;
        check("if_done", if_done, 1);
        check("if_err", if_err, 0);
        check("if_rdata", if_rdata, 32'h0013_0513);
        check("if_mem_done_quiet", mem_done, 0);
        if_req = 1'b0;
        step();
        check("if_done_clear", if_done, 0);

        // Contention: MEM x4 then IF x1, ack on the second BUSY cycle
        mem_req = 1'b1; mem_addr = 64'h200; mem_wdata = 64'h55; mem_rd_ctrl = RD_CTRL_DWORD;
        if_req = 1'b1; if_addr = 64'h300;
        last_if = -1;
        for (int g = 0; g < 10; g++) begin
            exp_if = ((g % 5) == 4);
            wait_req(ok);
            check("cont_req_seen", ok, 1);
            check("cont_owner_addr", dm_addr, exp_if ? 64'h300 : 64'h200);
            step();
            check("cont_hold_req", dm_req, 1);
            dm_ack = 1'b1; dm_dout = 64'hA000_0000_0000_1000 + 64'(g);
            step();
            dm_ack = 1'b0;
            if (exp_if) begin
                check("cont_if_done", if_done, 1);
                check("cont_if_rdata", if_rdata, 32'h1000 + 32'(g));
                check("cont_if_gap", (g - last_if) <= 5, 1);
                last_if = g;
            end else begin
                check("cont_mem_done", mem_done, 1);
                check("cont_mem_rdata", mem_rdata, 64'hA000_0000_0000_1000 + 64'(g));
                check("cont_if_idle", if_done, 0);
            end
            if (g == 9) begin
                mem_req = 1'b0;
                if_req  = 1'b0;
            end
            step();
        end

        // No-op MEM: no memory access, done on the cycle after the grant
        mem_req = 1'b1; mem_addr = 64'h500; mem_rd_ctrl = RD_CTRL_NONE; mem_wr_ctrl = WR_CTRL_NONE;
        step();
        check("noop_dm_req", dm_req, 0);
        check("noop_done", mem_done, 1);
        check("noop_err", mem_err, 0);
        check("noop_rdata", mem_rdata, 0);
        check("noop_state", dbg_state, HOLD);
        mem_req = 1'b0;
        step();
        check("noop_done_clear", mem_done, 0);

        // Store timeout: no ack ever
        mem_req = 1'b1; mem_addr = 64'h400; mem_wdata = 64'hCAFE_F00D;
        mem_rd_ctrl = RD_CTRL_NONE; mem_wr_ctrl = WR_CTRL_DWORD;
        step();
        check("to_dm_req", dm_req, 1);
        check("to_dm_din", dm_din, 64'hCAFE_F00D);
        check("to_dm_wr_ctrl", dm_wr_ctrl, WR_CTRL_DWORD);
        mem_addr = 64'h999; mem_wdata = 64'h0;
        busy_cnt = 1;
        for (int i = 0; i < 254; i++) begin
            step();
            if (dm_req) busy_cnt++;
        end
        check("to_busy_cycles", busy_cnt, 255);
        check("to_addr_held", dm_addr, 64'h400);
        check("to_din_held", dm_din, 64'hCAFE_F00D);
        check("to_not_done_yet", mem_done, 0);
        step();
        check("to_dm_req_drop", dm_req, 0);
        check("to_done", mem_done, 1);
        check("to_err", mem_err, 1);
        check("to_rdata", mem_rdata, 0);
        mem_req = 1'b0;
        dm_ack = 1'b1; dm_dout = '1;
        step();
        check("stray_hold_done", {mem_done, mem_err, if_done, dm_req}, 0);
        check("stray_state", dbg_state, IDLE);
        step();
        check("stray_idle_quiet", {mem_done, mem_err, if_done, dm_req}, 0);
        check("stray_rdata", mem_rdata, 0);
        dm_ack = 1'b0;

        // Reset in the third BUSY cycle, fetch pending
        mem_req = 1'b1; mem_addr = 64'h600; mem_rd_ctrl = RD_CTRL_DWORD; mem_wr_ctrl = WR_CTRL_NONE;
        step(); step(); step();
        check("rst_mid_busy", dm_req, 1);
        if_req = 1'b1; if_addr = 64'h700;
        #3 reset = 1'b1;
        #1;
        check("rst_mid_dm_req", dm_req, 0);
        check("rst_mid_dm_addr", dm_addr, 0);
        check("rst_mid_done", {mem_done, mem_err, if_done, if_err}, 0);
        mem_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_rel_mem_done", mem_done, 0);
        wait_req(ok);
        check("rst_if_grant", ok, 1);
        check("rst_if_addr", dm_addr, 64'h700);
        check("rst_if_rd_ctrl", dm_rd_ctrl, RD_CTRL_WORD_U);
        d = 64'h0BAD_0000_0000_0073;
        dm_ack = 1'b1; dm_dout = d;
        step();
        dm_ack = 1'b0;
        check("rst_if_done", if_done, 1);
        check("rst_if_rdata", if_rdata, 32'h0000_0073);
        check("rst_mem_quiet", mem_done, 0);
        if_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
Name: pipeline_mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: the MEM stage (load/store) and instruction fetch.
- Sequences each access as a req/ack transaction against a variable-latency memory and returns a one-cycle done pulse to the winner.
- Generates per-requester stall signals.
- Sits between pipeline_mem_stage/IF stage and the unified memory model; MEM has priority, bounded by an anti-starvation streak limit.

Parameters:
- MAX_MEM_STREAK, 4: consecutive MEM grants allowed while if_req waits; the next grant goes to IF.
- TIMEOUT_CYCLES, 255: BUSY cycles without dm_ack before the access is aborted with an error.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req  in  1  MEM-stage request; fields held stable until mem_done
- mem_addr  in  64  MEM byte address
- mem_wdata  in  64  MEM store data
- mem_rd_ctrl  in  3  MEM read control (decoder encoding)
- mem_wr_ctrl  in  2  MEM write control (decoder encoding)
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  valid with mem_done; timeout
- mem_rdata  out  64  load data, valid with mem_done
- mem_stall  out  1  mem_req & ~mem_done (combinational)
- if_req  in  1  fetch request; held until if_done
- if_addr  in  64  fetch address
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  valid with if_done
- if_rdata  out  32  instruction, dm_dout[31:0] captured at ack
- if_stall  out  1  if_req & ~if_done (combinational)
- dm_req  out  1  memory request, held until dm_ack or timeout
- dm_addr  out  64  memory address
- dm_din  out  64  memory write data
- dm_rd_ctrl  out  3  memory read control
- dm_wr_ctrl  out  2  memory write control
- dm_ack  in  1  one-cycle completion from memory; dm_dout valid with it
- dm_dout  in  64  memory read data

Behaviour:
- Reset is asynchronous and active-high. On reset, all outputs are 0, state is IDLE, streak=0, timeout counter=0.
- Reset mid-transaction drops dm_req immediately; the access is lost and no done pulse is issued.
- FSM states: IDLE, BUSY, HOLD.
- IDLE: at the clock edge, evaluate requests:
  - IF is granted if if_req and (!mem_req or streak==MAX_MEM_STREAK).
  - Otherwise MEM is granted if mem_req.
  - The winner's fields are latched into dm_addr, dm_din, dm_rd_ctrl and dm_wr_ctrl, and the owner is recorded.
  - IF grants drive dm_rd_ctrl=RD_CTRL_WORD_U, dm_wr_ctrl=0, dm_din=0.
- MEM grant with mem_rd_ctrl==0 and mem_wr_ctrl==0 (no-op): go directly to HOLD without asserting dm_req; mem_done=1, mem_rdata=0.
- Otherwise go to BUSY with dm_req=1.
- Streak counter:
  - MEM grant while if_req=1: streak+1, saturating at MAX_MEM_STREAK.
  - MEM grant while if_req=0: streak=0.
  - Any IF grant: streak=0.
- BUSY, dm_ack=1: at the edge, deassert dm_req, capture read data into the owner's rdata (mem_rdata=dm_dout; if_rdata=dm_dout[31:0]), set the owner's done=1 with err=0, go to HOLD.
- BUSY, no ack: the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without ack: drop dm_req, go to HOLD, owner done=1, err=1, rdata=0.
- HOLD lasts one cycle: the done pulse is visible; no grant is made; done and err are cleared at the next edge; go to IDLE.
  - This bubble lets registered requesters update req after seeing done.
- Stray dm_ack in IDLE or HOLD (late ack after a timeout) is ignored; no output changes.
- Write-only accesses: rdata is still updated from dm_dout at ack; the requester ignores it.
- Latency with a zero-wait memory (dm_ack in the first BUSY cycle):
  - req sampled at edge 0 → dm_req high in cycle 1 → done high in cycle 2 → next grant possible at edge 3.
  - Throughput is one access per 3 cycles minimum.
- dm_* fields are held constant for the whole BUSY state regardless of requester input changes.

Decomposition:
- Package pipeline_mem_pkg:
  - state enum {IDLE, BUSY, HOLD}
  - owner enum {OWN_MEM, OWN_IF}
  - RD_CTRL_WORD_U and other dm_rd_ctrl/dm_wr_ctrl encodings, shared with the decoder
- Sub-module pipeline_mem_arb_pick: combinational grant selection from mem_req, if_req and streak; returns grant_mem/grant_if.
- Everything else, including the FSM, counters and the output register file, stays in pipeline_mem_arbiter.

Test Plan:
- MEM load only: mem_req=1, mem_addr=0x100, mem_rd_ctrl=LD, dm_ack in cycle 1 with dm_dout=0xDEAD_BEEF_0000_0001 → dm_req high cycle 1 only, mem_done pulse cycle 2 with mem_rdata=0xDEADBEEF00000001, mem_stall low cycle 2, mem_err=0.
- Contention: mem_req and if_req both held high continuously, ack after 2 cycles → grant order MEM×4 then IF×1, repeating; if_done never more than 5 transactions apart.
- IF fetch: if_addr=0x80, dm_dout=0x1234_5678_0013_0513 → dm_rd_ctrl=RD_CTRL_WORD_U, dm_wr_ctrl=0, if_rdata=0x00130513.
- Timeout: MEM store with dm_ack never asserted → dm_req drops after 255 BUSY cycles, mem_done=1 and mem_err=1 for one cycle; a later stray dm_ack changes nothing.
- No-op MEM (rd_ctrl=0, wr_ctrl=0) → dm_req never asserted, mem_done on the cycle after the grant, mem_rdata=0.
- Reset asserted in the 3rd BUSY cycle → dm_req, dm_addr and all done/err outputs go to 0 asynchronously, no done pulse; after release, a pending if_req is granted from IDLE normally.
